// File: rtl/q_learn_pkg.sv
// Shared Q-learning types and constants: Q16.16 values, maze state/action indices, LFSR step.
package q_learn_pkg;

    localparam int unsigned Q_W         = 32;
    localparam int unsigned Q_FRAC      = 16;
    localparam int unsigned NUM_STATES  = 37;
    localparam int unsigned NUM_ACTIONS = 4;
    localparam int unsigned STATE_W     = 6;
    localparam int unsigned ACT_W       = 3;
    localparam int unsigned IDX_W       = 2;
    localparam int unsigned LFSR_W      = 16;

    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    typedef logic signed [Q_W-1:0] q_t;
    typedef logic [STATE_W-1:0]    state_t;
    typedef logic [ACT_W-1:0]      action_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DRAIN,
        S_DECIDE
    } sel_state_e;

    // One step of the right-shifting Galois LFSR.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
        return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR; a zero seed is replaced by 1 so the sequence never locks up.
module lfsr16
    import q_learn_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] q
);

    logic [LFSR_W-1:0] seed_safe;

    assign seed_safe = (seed == '0) ? LFSR_W'(1) : seed;

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= seed_safe;
        end else begin
            q <= lfsr_step(q);
        end
    end

endmodule

// File: rtl/q_action_select.sv
// Scans the four Q-table entries of one maze state and returns max Q, greedy action
// and the epsilon-greedy chosen action.
module q_action_select
    import q_learn_pkg::*;
#(
    parameter logic [7:0]        EPSILON   = 8'd26,
    parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    start,
    input  state_t  state_in,
    input  logic    explore_en,
    output logic    rd_en,
    output state_t  rd_state,
    output action_t rd_action,
    input  q_t      rd_data,
    output logic    busy,
    output logic    out_valid,
    output q_t      max_q,
    output action_t best_action,
    output action_t chosen_action,
    output logic    explored,
    output logic    err
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ACTIONS - 1);

    sel_state_e        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d, ridx_q, run_best_q, run_best_d;
    state_t            st_q, st_d;
    logic              expl_q, expl_d, bad_q, bad_d;
    logic              rd_en_q, rd_en_d, rv_q;
    logic              busy_q, busy_d, out_valid_q, out_valid_d;
    q_t                run_max_q, run_max_d, max_q_q, max_q_d;
    action_t           best_q, best_d, chosen_q, chosen_d;
    logic              explored_q, explored_d, err_q, err_d;
    logic [LFSR_W-1:0] lfsr;
    logic              out_of_range;
    logic              unused_lfsr_hi;

    lfsr16 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .seed (LFSR_SEED),
        .q    (lfsr)
    );

    assign unused_lfsr_hi = ^lfsr[LFSR_W-1:10];
    assign out_of_range   = (state_in >= STATE_W'(NUM_STATES));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = out_of_range ? S_DECIDE : S_SCAN;
            S_SCAN:   if (idx_q == LAST_IDX) state_d = S_DRAIN;
            S_DRAIN:  state_d = S_DECIDE;
            S_DECIDE: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        idx_d       = idx_q;
        st_d        = st_q;
        expl_d      = expl_q;
        bad_d       = bad_q;
        rd_en_d     = 1'b0;
        busy_d      = busy_q;
        run_max_d   = run_max_q;
        run_best_d  = run_best_q;
        out_valid_d = 1'b0;
        max_q_d     = max_q_q;
        best_d      = best_q;
        chosen_d    = chosen_q;
        explored_d  = explored_q;
        err_d       = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    st_d       = state_in;
                    expl_d     = explore_en;
                    bad_d      = out_of_range;
                    busy_d     = 1'b1;
                    run_max_d  = '0;
                    run_best_d = '0;
                    idx_d      = '0;
                    rd_en_d    = !out_of_range;
                end
            end
            S_SCAN: begin
                idx_d   = IDX_W'(idx_q + 1'b1);
                rd_en_d = (idx_q != LAST_IDX);
            end
            S_DECIDE: begin
                out_valid_d = 1'b1;
                busy_d      = 1'b0;
                err_d       = bad_q;
                if (bad_q) begin
                    max_q_d    = '0;
                    best_d     = '0;
                    chosen_d   = '0;
                    explored_d = 1'b0;
                end else begin
                    max_q_d = run_max_q;
                    best_d  = action_t'(run_best_q);
                    if (expl_q && (lfsr[7:0] < EPSILON)) begin
                        chosen_d   = action_t'(lfsr[9:8]);
                        explored_d = 1'b1;
                    end else begin
                        chosen_d   = action_t'(run_best_q);
                        explored_d = 1'b0;
                    end
                end
            end
            default: ;
        endcase
        // Returning read data: first entry seeds the max, later ones must strictly beat it.
        if (rv_q && ((ridx_q == '0) || ($signed(rd_data) > $signed(run_max_q)))) begin
            run_max_d  = rd_data;
            run_best_d = ridx_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q       <= '0;
            ridx_q      <= '0;
            st_q        <= '0;
            expl_q      <= 1'b0;
            bad_q       <= 1'b0;
            rd_en_q     <= 1'b0;
            rv_q        <= 1'b0;
            busy_q      <= 1'b0;
            run_max_q   <= '0;
            run_best_q  <= '0;
            out_valid_q <= 1'b0;
            max_q_q     <= '0;
            best_q      <= '0;
            chosen_q    <= '0;
            explored_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            ridx_q      <= idx_q;
            st_q        <= st_d;
            expl_q      <= expl_d;
            bad_q       <= bad_d;
            rd_en_q     <= rd_en_d;
            rv_q        <= rd_en_q;
            busy_q      <= busy_d;
            run_max_q   <= run_max_d;
            run_best_q  <= run_best_d;
            out_valid_q <= out_valid_d;
            max_q_q     <= max_q_d;
            best_q      <= best_d;
            chosen_q    <= chosen_d;
            explored_q  <= explored_d;
            err_q       <= err_d;
        end
    end

    assign rd_en         = rd_en_q;
    assign rd_state      = st_q;
    assign rd_action     = action_t'(idx_q);
    assign busy          = busy_q;
    assign out_valid     = out_valid_q;
    assign max_q         = max_q_q;
    assign best_action   = best_q;
    assign chosen_action = chosen_q;
    assign explored      = explored_q;
    assign err           = err_q;

endmodule
